// File: rtl/pipe_perf_monitor_if.sv
// rtl/pipe_perf_monitor_if.sv - CPU event and counter readout bundle for pipe_perf_monitor
interface pipe_perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             stall_i;
  logic             flush_i;
  logic             retire_i;
  logic [31:0]      pc_i;
  logic             rd_req_i;
  logic [1:0]       rd_sel_i;
  logic             rd_valid_o;
  logic [CNT_W-1:0] rd_data_o;
  logic             running_o;
  logic             done_o;
  logic             hang_o;
  logic             sat_o;

  modport master (
    output start_i, stall_i, flush_i, retire_i, pc_i, rd_req_i, rd_sel_i,
    input  rd_valid_o, rd_data_o, running_o, done_o, hang_o, sat_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, retire_i, pc_i, rd_req_i, rd_sel_i,
    output rd_valid_o, rd_data_o, running_o, done_o, hang_o, sat_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline event counters with cycle-limit/hang stop and counter readout
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int HANG_LIMIT  = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pipe_perf_monitor_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int HW = $clog2(HANG_LIMIT + 1);
  localparam int LW = (CNT_W > 32) ? CNT_W : 32;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cycle_cnt, r_stall_cnt, r_flush_cnt, r_retire_cnt;
  logic [31:0]      r_prev_pc;
  logic [HW-1:0]    r_hang_cnt;
  logic             r_rd_valid, r_hang, r_sat;
  logic [CNT_W-1:0] r_rd_data;

  logic             w_count;
  logic             w_cycle_full, w_stall_full, w_flush_full, w_retire_full;
  logic [CNT_W-1:0] w_cycle_next, w_stall_next, w_flush_next, w_retire_next;
  logic             w_sat_hit, w_same_pc, w_hang_hit, w_limit_hit;
  logic [HW-1:0]    w_hang_next;
  logic [CNT_W-1:0] w_rd_mux;

  assign w_count = (r_state == S_RUN) && bus.start_i;

  // Saturating increments: a full counter holds instead of wrapping.
  assign w_cycle_full  = &r_cycle_cnt;
  assign w_stall_full  = &r_stall_cnt;
  assign w_flush_full  = &r_flush_cnt;
  assign w_retire_full = &r_retire_cnt;
  assign w_cycle_next  = w_cycle_full ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
  assign w_stall_next  = (bus.stall_i && !w_stall_full) ? r_stall_cnt + CNT_W'(1) : r_stall_cnt;
  assign w_flush_next  = (bus.flush_i && !w_flush_full) ? r_flush_cnt + CNT_W'(1) : r_flush_cnt;
  assign w_retire_next = (bus.retire_i && !w_retire_full) ? r_retire_cnt + CNT_W'(1) : r_retire_cnt;
  assign w_sat_hit     = w_count && (w_cycle_full || (bus.stall_i && w_stall_full) ||
                                     (bus.flush_i && w_flush_full) || (bus.retire_i && w_retire_full));

  assign w_same_pc   = (bus.pc_i == r_prev_pc) && !bus.stall_i;
  assign w_hang_next = w_same_pc ? r_hang_cnt + HW'(1) : '0;
  assign w_hang_hit  = w_count && (w_hang_next == HW'(HANG_LIMIT));
  // Compare in a width that can hold the limit even when CNT_W is narrow.
  assign w_limit_hit = w_count && (LW'(w_cycle_next) == LW'(CYCLE_LIMIT));

  always_comb begin
    w_rd_mux = r_cycle_cnt;
    case (bus.rd_sel_i)
      2'd0:    w_rd_mux = r_cycle_cnt;
      2'd1:    w_rd_mux = r_stall_cnt;
      2'd2:    w_rd_mux = r_flush_cnt;
      default: w_rd_mux = r_retire_cnt;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_cycle_cnt  <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
      r_prev_pc    <= '0;
      r_hang_cnt   <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_hang       <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_req_i;
      if (bus.rd_req_i) r_rd_data <= w_rd_mux;
      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state    <= S_RUN;
            r_prev_pc  <= bus.pc_i;
            r_hang_cnt <= '0;
          end
        end
        S_RUN: begin
          if (!bus.start_i) begin
            r_state <= S_IDLE;
          end else begin
            r_cycle_cnt  <= w_cycle_next;
            r_stall_cnt  <= w_stall_next;
            r_flush_cnt  <= w_flush_next;
            r_retire_cnt <= w_retire_next;
            r_prev_pc    <= bus.pc_i;
            r_hang_cnt   <= w_hang_next;
            if (w_sat_hit) r_sat <= 1'b1;
            if (w_hang_hit) r_hang <= 1'b1;
            if (w_hang_hit || w_limit_hit) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_valid_o = r_rd_valid;
  assign bus.rd_data_o  = r_rd_data;
  assign bus.running_o  = (r_state == S_RUN);
  assign bus.done_o     = (r_state == S_DONE);
  assign bus.hang_o     = r_hang;
  assign bus.sat_o      = r_sat;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - directed bench for pipe_perf_monitor
module tb_pipe_perf_monitor;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  pipe_perf_monitor_if #(.CNT_W(32)) bus ();
  pipe_perf_monitor_if #(.CNT_W(4))  sbus ();

  pipe_perf_monitor #(.CNT_W(32)) u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  pipe_perf_monitor #(.CNT_W(4)) u_sat (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (sbus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic zero_inputs();
    bus.start_i   = 1'b0; bus.stall_i  = 1'b0; bus.flush_i  = 1'b0; bus.retire_i = 1'b0;
    bus.pc_i      = 32'h0; bus.rd_req_i = 1'b0; bus.rd_sel_i = 2'd0;
    sbus.start_i  = 1'b0; sbus.stall_i  = 1'b0; sbus.flush_i  = 1'b0; sbus.retire_i = 1'b0;
    sbus.pc_i     = 32'h0; sbus.rd_req_i = 1'b0; sbus.rd_sel_i = 2'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    zero_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic read(input logic [1:0] sel, input logic [31:0] exp, input string tag);
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = sel;
    tick();
    bus.rd_req_i = 1'b0;
    chk_bit({tag, "_valid"}, bus.rd_valid_o, 1'b1);
    chk_val(tag, bus.rd_data_o, exp);
  endtask

  // Stimulus for the cycle-limit run: 3 stalls (5..7), 2 flushes (7..8), 20 retires (10..29).
  task automatic drive_cycle(input int i);
    bus.pc_i     = 32'(4 * (i + 1));
    bus.stall_i  = (i >= 5 && i <= 7);
    bus.flush_i  = (i == 7 || i == 8);
    bus.retire_i = (i >= 10);
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    zero_inputs();

    // Reset state and idle hold
    do_reset();
    chk_bit("rst_running", bus.running_o, 1'b0);
    chk_bit("rst_done", bus.done_o, 1'b0);
    chk_bit("rst_hang", bus.hang_o, 1'b0);
    chk_bit("rst_sat", bus.sat_o, 1'b0);
    chk_bit("rst_valid", bus.rd_valid_o, 1'b0);
    chk_val("rst_data", bus.rd_data_o, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk_bit("idle_running", bus.running_o, 1'b0);
    read(2'd0, 32'd0, "idle_cycle");
    tick();
    chk_bit("valid_one_cycle", bus.rd_valid_o, 1'b0);

    // Full run to the cycle limit
    do_reset();
    bus.start_i = 1'b1;
    tick();
    chk_bit("run_entry", bus.running_o, 1'b1);
    for (int i = 0; i < 29; i++) drive_cycle(i);
    chk_bit("pre_limit_done", bus.done_o, 1'b0);
    chk_bit("pre_limit_running", bus.running_o, 1'b1);
    drive_cycle(29);
    chk_bit("limit_done", bus.done_o, 1'b1);
    chk_bit("limit_running", bus.running_o, 1'b0);
    chk_bit("limit_hang", bus.hang_o, 1'b0);
    bus.stall_i = 1'b1; bus.flush_i = 1'b1; bus.retire_i = 1'b1; bus.start_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.start_i = 1'b1;
    tick();
    tick();
    chk_bit("done_sticky", bus.done_o, 1'b1);
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = 2'd1;
    tick();
    chk_bit("b2b_valid1", bus.rd_valid_o, 1'b1);
    chk_val("b2b_stall", bus.rd_data_o, 32'd3);
    bus.rd_sel_i = 2'd2;
    tick();
    chk_bit("b2b_valid2", bus.rd_valid_o, 1'b1);
    chk_val("b2b_flush", bus.rd_data_o, 32'd2);
    bus.rd_sel_i = 2'd3;
    tick();
    chk_bit("b2b_valid3", bus.rd_valid_o, 1'b1);
    chk_val("b2b_retire", bus.rd_data_o, 32'd20);
    bus.rd_req_i = 1'b0;
    tick();
    chk_bit("b2b_valid_drop", bus.rd_valid_o, 1'b0);
    chk_val("rd_data_hold", bus.rd_data_o, 32'd20);
    read(2'd0, 32'd30, "limit_cycle");

    // Pause and resume: 10 + 5 counted cycles
    do_reset();
    bus.start_i = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.pc_i = bus.pc_i + 32'd4;
      tick();
    end
    bus.start_i = 1'b0;
    tick();
    chk_bit("pause_running", bus.running_o, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk_bit("pause_running_end", bus.running_o, 1'b0);
    chk_bit("pause_done", bus.done_o, 1'b0);
    bus.start_i = 1'b1;
    tick();
    chk_bit("resume_running", bus.running_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.pc_i = bus.pc_i + 32'd4;
      tick();
    end
    bus.start_i = 1'b0;
    tick();
    read(2'd0, 32'd15, "pause_cycle");

    // Frozen PC without stall hangs on the 8th repeat
    do_reset();
    bus.pc_i = 32'h10;
    bus.start_i = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk_bit("hang_pre7", bus.hang_o, 1'b0);
    chk_bit("hang_pre7_done", bus.done_o, 1'b0);
    tick();
    chk_bit("hang_set", bus.hang_o, 1'b1);
    chk_bit("hang_done", bus.done_o, 1'b1);
    read(2'd0, 32'd8, "hang_cycle");

    // Frozen PC with stall, then a 7-cycle freeze broken by a PC change
    do_reset();
    bus.pc_i = 32'h10;
    bus.stall_i = 1'b1;
    bus.start_i = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) tick();
    chk_bit("stall_nohang", bus.hang_o, 1'b0);
    bus.stall_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk_bit("freeze7_nohang", bus.hang_o, 1'b0);
    bus.pc_i = 32'h14;
    tick();
    chk_bit("pc_change_nohang", bus.hang_o, 1'b0);
    chk_bit("pc_change_running", bus.running_o, 1'b1);
    for (int i = 0; i < 7; i++) tick();
    chk_bit("refreeze_nohang", bus.hang_o, 1'b0);
    chk_bit("refreeze_done", bus.done_o, 1'b0);
    read(2'd1, 32'd12, "stall_count");

    // Narrow counters saturate
    do_reset();
    sbus.start_i = 1'b1;
    tick();
    sbus.stall_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk_bit("sat_set", sbus.sat_o, 1'b1);
    chk_bit("sat_not_done", sbus.done_o, 1'b0);
    chk_bit("sat_main_clear", bus.sat_o, 1'b0);
    sbus.rd_req_i = 1'b1;
    sbus.rd_sel_i = 2'd1;
    tick();
    sbus.rd_req_i = 1'b0;
    chk_bit("sat_rd_valid", sbus.rd_valid_o, 1'b1);
    chk_val("sat_stall", 32'(sbus.rd_data_o), 32'd15);
    sbus.rd_req_i = 1'b1;
    sbus.rd_sel_i = 2'd0;
    tick();
    sbus.rd_req_i = 1'b0;
    chk_val("sat_cycle", 32'(sbus.rd_data_o), 32'd15);

    // Asynchronous reset mid-run drops a pending readout at once
    do_reset();
    bus.start_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.pc_i = bus.pc_i + 32'd4;
      tick();
    end
    bus.rd_req_i = 1'b1;
    bus.rd_sel_i = 2'd0;
    tick();
    bus.rd_req_i = 1'b0;
    chk_bit("pre_arst_valid", bus.rd_valid_o, 1'b1);
    chk_val("pre_arst_data", bus.rd_data_o, 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_bit("arst_running", bus.running_o, 1'b0);
    chk_bit("arst_valid", bus.rd_valid_o, 1'b0);
    chk_val("arst_data", bus.rd_data_o, 32'd0);
    zero_inputs();
    tick();
    rst_n = 1'b1;
    read(2'd0, 32'd0, "arst_cycle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_perf_monitor.md
Name: pipe_perf_monitor

Overview:
- Event monitor directly downstream of the 5-stage pipelined CPU; consumes its start, stall (hazard bubble), flush, retire and PC signals.
- Accumulates cycle, stall, flush and retired-instruction counts.
- Stops the run at a programmable cycle limit, or when the PC hangs.
- Exposes a one-cycle-latency counter readout so benches and debug logic read counts without hierarchical references.

Parameters:
CNT_W, 32, width of every event counter and of rd_data_o
CYCLE_LIMIT, 30, RUN cycles counted before entering DONE
HANG_LIMIT, 8, consecutive unchanged, unstalled PC cycles that flag a hang

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
start_i  input  1  CPU start; high enables counting
stall_i  input  1  hazard unit bubble/stall this cycle
flush_i  input  1  IF/ID flush this cycle
retire_i  input  1  instruction leaving MEM/WB this cycle (not a bubble)
pc_i  input  32  current PC register value
rd_req_i  input  1  readout request, one cycle per request
rd_sel_i  input  2  0=cycle, 1=stall, 2=flush, 3=retire
rd_valid_o  output  1  readout data valid
rd_data_o  output  CNT_W  readout data
running_o  output  1  state==RUN
done_o  output  1  state==DONE
hang_o  output  1  hang detected (sticky)
sat_o  output  1  any counter saturated (sticky)

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE. All counters 0, hang counter 0, prev_pc 0. rd_valid_o=0, rd_data_o=0, running_o=0, done_o=0, hang_o=0, sat_o=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when start_i=1 at an edge. No counting on that edge.
  - RUN->IDLE when start_i=0 at an edge (pause). Counters hold; no counting on that edge.
  - RUN->DONE on the edge where cycle_cnt becomes CYCLE_LIMIT, or where hang_o sets.
  - DONE is terminal until reset; start_i is ignored.
- Counting, on each edge while in RUN with start_i=1:
  - cycle_cnt += 1.
  - stall_cnt += stall_i; flush_cnt += flush_i; retire_cnt += retire_i. Increments are independent; simultaneous events each count.
  - Counters saturate at 2^CNT_W-1 with no wrap. The first saturating increment sets sat_o.
- Hang detection, evaluated only in RUN:
  - prev_pc <= pc_i every RUN cycle.
  - If pc_i==prev_pc and stall_i=0, hang_cnt += 1; otherwise hang_cnt <= 0.
  - When hang_cnt would reach HANG_LIMIT: set hang_o and go to DONE on that edge.
  - On IDLE->RUN entry, prev_pc loads pc_i and hang_cnt clears.
  - If hang and limit coincide on the same edge, both cause DONE and hang_o sets.
- Readout, accepted in every state including during reset release:
  - rd_req_i=1 at edge N: at edge N+1, rd_valid_o=1 and rd_data_o = selected counter value as it was before the edge N update.
  - rd_valid_o is high exactly one cycle per request. Back-to-back requests give back-to-back valids.
  - Without a request, rd_valid_o=0 and rd_data_o holds its last value.
- Reset asserted mid-run clears everything immediately, including a pending readout.

Test Plan:
- Reset, hold start_i=0 for 5 cycles -> all counters 0, running_o=0. Read sel 0 -> rd_data_o=0 one cycle after request.
- Reset, start_i=1; pc_i increments by 4 each cycle; stall_i high for 3 cycles and flush_i high for 2 (1 overlapping the stalls); retire_i high 20 cycles -> done_o rises on the edge cycle_cnt hits 30. Reads then give cycle=30, stall=3, flush=2, retire=20. Further events are ignored.
- Run 10 cycles, drop start_i for 4 cycles, raise again for 5 -> cycle_cnt=15, running_o low during the pause.
- Hang check, pc_i frozen at 0x10 with stall_i=0 -> hang_o and done_o set on the 8th repeat edge.
- Same frozen PC with stall_i=1 -> no hang. Clear stall, freeze 7 cycles, change pc_i -> hang_o stays 0.
- CNT_W=4, stall_i constantly high -> stall_cnt stops at 15 and sat_o sets.
- Back-to-back reads sel 1,2,3 -> three consecutive valids with correct values.
- Assert rst_n_i mid-run between clock edges -> outputs zero immediately.
